// File: rtl/mop_instr_buffer.sv
// Micro-op instruction buffer: collects a sequence of instruction words from
// the micro-op loader, then issues them in order over a valid/ready handshake,
// optionally replaying the whole sequence once before signalling completion.
module mop_instr_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned RED_LEN    = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    load_i,
    input  logic [DATA_WIDTH-1:0]   instr_i,
    input  logic [1:0]              change_i,
    input  logic                    flush_i,
    output logic [DATA_WIDTH-1:0]   instr_o,
    output logic                    instr_valid_o,
    input  logic                    instr_ready_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    overflow_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH) + 1;
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LEN_NORM = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] LEN_RED  = PTR_W'(RED_LEN);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        ISSUE,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              pass_q, pass_d;
    logic [1:0]        mode_q, mode_d;
    logic              filled_q, filled_d;
    logic              overflow_q, overflow_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_waddr;

    logic [PTR_W-1:0]  len;
    logic              hs;

    assign len = mode_q[1] ? LEN_RED : LEN_NORM;
    assign hs  = (state_q == ISSUE) && instr_ready_i;

    // State and control registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pass_q     <= 1'b0;
            mode_q     <= '0;
            filled_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pass_q     <= pass_d;
            mode_q     <= mode_d;
            filled_q   <= filled_d;
            overflow_q <= overflow_d;
        end
    end

    // Buffer storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_waddr] <= instr_i;
        end
    end

    // Next-state, pointer and write-enable logic; flush overrides everything
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pass_d     = pass_q;
        mode_d     = mode_q;
        filled_d   = filled_q;
        overflow_d = overflow_q;
        mem_we     = 1'b0;
        mem_waddr  = '0;

        if (flush_i) begin
            state_d    = IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            pass_d     = 1'b0;
            filled_d   = 1'b0;
            overflow_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load_i) begin
                        mem_we    = 1'b1;
                        mem_waddr = '0;
                        mode_d    = change_i;
                        wr_ptr_d  = PTR_ONE;
                        filled_d  = 1'b0;
                        state_d   = FILL;
                    end
                end
                FILL: begin
                    // filled_q delays the ISSUE entry by one cycle after
                    // wr_ptr reaches len, giving the two-cycle first-word latency
                    if (filled_q) begin
                        state_d = ISSUE;
                    end else if (wr_ptr_q == len) begin
                        filled_d = 1'b1;
                    end
                    if (load_i) begin
                        if (wr_ptr_q < len) begin
                            mem_we    = 1'b1;
                            mem_waddr = wr_ptr_q[ADDR_W-1:0];
                            wr_ptr_d  = wr_ptr_q + PTR_ONE;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (load_i) begin
                        overflow_d = 1'b1;
                    end
                    if (hs) begin
                        if (rd_ptr_q == (len - PTR_ONE)) begin
                            if (mode_q[0] && !pass_q) begin
                                rd_ptr_d = '0;
                                pass_d   = 1'b1;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            rd_ptr_d = rd_ptr_q + PTR_ONE;
                        end
                    end
                end
                DONE: begin
                    if (load_i) begin
                        overflow_d = 1'b1;
                    end
                    state_d  = IDLE;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    pass_d   = 1'b0;
                    filled_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        instr_valid_o = (state_q == ISSUE);
        instr_o       = (state_q == ISSUE) ? mem[rd_ptr_q[ADDR_W-1:0]] : '0;
        busy_o        = (state_q != IDLE);
        done_o        = (state_q == DONE);
        overflow_o    = overflow_q;
        count_o       = ((state_q == FILL) || (state_q == ISSUE)) ? wr_ptr_q : '0;
    end

endmodule

// File: tb/tb_mop_instr_buffer.sv
// Randomized self-checking bench for mop_instr_buffer. The reference is a
// queue of the words expected to leave the buffer, built from the loaded
// words and the requested mode.
module tb_mop_instr_buffer;

    localparam int unsigned DW      = 32;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned RED_LEN = 4;

    logic                  clk_i;
    logic                  rst_ni;
    logic                  load_i;
    logic [DW-1:0]         instr_i;
    logic [1:0]            change_i;
    logic                  flush_i;
    logic [DW-1:0]         instr_o;
    logic                  instr_valid_o;
    logic                  instr_ready_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  overflow_o;
    logic [$clog2(DEPTH):0] count_o;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    logic [DW-1:0] words[$];

    mop_instr_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .RED_LEN    (RED_LEN)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .load_i        (load_i),
        .instr_i       (instr_i),
        .change_i      (change_i),
        .flush_i       (flush_i),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .overflow_o    (overflow_o),
        .count_o       (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Load the first n entries of `words`, with random idle gaps and random
    // change_i values while filling (these must be ignored).
    task automatic load_words(input logic [1:0] mode, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) begin
                load_i   = 1'b0;
                change_i = 2'($urandom);
                step();
                check("cnt_gap", 32'(count_o), i);
                check("valid_gap", 32'(instr_valid_o), 0);
            end
            load_i   = 1'b1;
            instr_i  = words[i];
            change_i = (i == 0) ? mode : 2'($urandom);
            step();
            load_i = 1'b0;
            check("cnt_fill", 32'(count_o), i + 1);
            check("busy_fill", 32'(busy_o), 1);
            check("valid_fill", 32'(instr_valid_o), 0);
        end
    endtask

    // One complete sequence: fill, issue with random backpressure, done.
    task automatic run_seq(input logic [1:0] mode, input int unsigned stall_pct,
                           input bit poke, input bit hold2, input int base);
        int unsigned len;
        int unsigned cyc;
        int unsigned held;
        int unsigned consumed;
        bit rdy;
        logic [DW-1:0] exp_q[$];

        len = mode[1] ? RED_LEN : DEPTH;
        words.delete();
        for (int unsigned i = 0; i < len; i++) begin
            if (base >= 0) words.push_back(DW'(base) + DW'(i));
            else           words.push_back(DW'($urandom));
        end
        load_words(mode, len);

        // Final word stored at the previous edge: valid must wait one more cycle
        step();
        check("lat_valid_lo", 32'(instr_valid_o), 0);
        check("lat_cnt", 32'(count_o), len);
        step();

        exp_q = words;
        if (mode[0]) begin
            foreach (words[i]) exp_q.push_back(words[i]);
        end

        cyc = 0;
        held = 0;
        consumed = 0;
        while (exp_q.size() > 0) begin
            if (cyc >= 500) begin
                check("issue_timeout", exp_q.size(), 0);
                break;
            end
            check("valid_issue", 32'(instr_valid_o), 1);
            check("instr", instr_o, exp_q[0]);
            check("cnt_issue", 32'(count_o), len);
            check("done_early", 32'(done_o), 0);
            rdy = ($urandom_range(0, 99) >= stall_pct);
            if (hold2 && consumed == 2 && held < 3) begin
                rdy = 1'b0;
                held++;
            end
            instr_ready_i = rdy;
            load_i  = poke && (cyc == 1);
            instr_i = DW'($urandom);
            step();
            cyc++;
            load_i = 1'b0;
            if (rdy) begin
                void'(exp_q.pop_front());
                consumed++;
            end
        end

        instr_ready_i = 1'($urandom_range(0, 1));
        check("done_pulse", 32'(done_o), 1);
        check("valid_done", 32'(instr_valid_o), 0);
        check("busy_done", 32'(busy_o), 1);
        check("cnt_done", 32'(count_o), 0);
        step();
        check("done_clr", 32'(done_o), 0);
        check("busy_idle", 32'(busy_o), 0);
        check("valid_idle", 32'(instr_valid_o), 0);
        check("overflow", 32'(overflow_o), poke ? 1 : 0);
        if (poke) begin
            flush_i = 1'b1;
            step();
            flush_i = 1'b0;
            check("ovf_flush", 32'(overflow_o), 0);
            check("busy_flush", 32'(busy_o), 0);
            check("cnt_flush", 32'(count_o), 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(instr_valid_o), 0);
        check({tag, "_busy"}, 32'(busy_o), 0);
        check({tag, "_done"}, 32'(done_o), 0);
        check({tag, "_ovf"}, 32'(overflow_o), 0);
        check({tag, "_cnt"}, 32'(count_o), 0);
        check({tag, "_instr"}, instr_o, 0);
    endtask

    initial begin
        rst_ni        = 1'b0;
        load_i        = 1'b0;
        instr_i       = '0;
        change_i      = '0;
        flush_i       = 1'b0;
        instr_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check_all_zero("rst");
        rst_ni = 1'b1;
        step();

        // Normal fill, deterministic words, full-rate consumer
        run_seq(2'b00, 0, 1'b0, 1'b0, 'h10);
        // Redirect with replay
        run_seq(2'b11, 0, 1'b0, 1'b0, 'hA0);
        // Backpressure held on word 2
        run_seq(2'b00, 0, 1'b0, 1'b1, -1);
        // Load during issue, then flush
        run_seq(2'b01, 20, 1'b1, 1'b0, -1);

        // Asynchronous reset after 5 of 8 words
        words.delete();
        for (int unsigned i = 0; i < DEPTH; i++) words.push_back(DW'($urandom));
        load_words(2'b00, 5);
        #2 rst_ni = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        check_all_zero("post_rst");
        run_seq(2'b00, 10, 1'b0, 1'b0, -1);

        // Same-cycle load and flush in IDLE: nothing is stored
        load_i  = 1'b1;
        flush_i = 1'b1;
        instr_i = DW'($urandom);
        step();
        load_i  = 1'b0;
        flush_i = 1'b0;
        check("ldfl_cnt", 32'(count_o), 0);
        check("ldfl_busy", 32'(busy_o), 0);
        step();
        check("ldfl_cnt2", 32'(count_o), 0);
        check("ldfl_busy2", 32'(busy_o), 0);

        // Randomized sequences
        repeat (12) begin
            run_seq(2'($urandom_range(0, 3)), $urandom_range(0, 50),
                    1'($urandom_range(0, 1)), 1'b0, -1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mop_instr_buffer.md
MOP_INSTR_BUFFER -- requirements
Module: mop_instr_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the instruction word width.
REQ-002 SHALL have parameter DEPTH, default 8, the buffer entries; the normal sequence length.
REQ-003 SHALL have parameter RED_LEN, default 4, the redirect sequence length.
REQ-004 SHALL provide ports (name  direction  width  meaning), with one clock, clk_i, and an asynchronous active-low reset, rst_ni:
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- load_i  input  1  one-cycle load strobe for this peripheral (one load_ctrl bit of the micro-op loader)
- instr_i  input  DATA_WIDTH  instruction word, valid when load_i=1
- change_i  input  2  mode: [1]=redirect (RED_LEN words, else DEPTH words); [0]=replay (issue sequence twice)
- flush_i  input  1  synchronous abort/clear
- instr_o  output  DATA_WIDTH  word being issued
- instr_valid_o  output  1  instr_o valid
- instr_ready_i  input  1  consumer accepts instr_o
- busy_o  output  1  state is not IDLE
- done_o  output  1  one-cycle pulse when the sequence is completed
- overflow_o  output  1  sticky: load_i was dropped
- count_o  output  $clog2(DEPTH)+1  words currently stored

Function
REQ-005 SHALL implement the FSM states IDLE, FILL, ISSUE and DONE.
REQ-006 In IDLE, load_i=1 SHALL:
- write instr_i to entry 0
- latch change_i
- set len = RED_LEN if change_i[1], else DEPTH
- set wr_ptr=1
- go to FILL
REQ-007 In FILL, load_i=1 SHALL write instr_i at wr_ptr and increment wr_ptr.
REQ-008 In FILL, the FSM SHALL go to ISSUE on the cycle after wr_ptr reaches len; change_i SHALL be ignored in FILL.
REQ-009 In ISSUE, instr_valid_o SHALL be 1 and instr_o SHALL be mem[rd_ptr], with instr_o stable while valid and not ready.
REQ-010 In ISSUE, a handshake (instr_valid_o && instr_ready_i) SHALL advance rd_ptr; there SHALL be at most one word per cycle.
REQ-011 On the handshake of word len-1:
- if the latched replay bit is set and pass=0: rd_ptr SHALL wrap to 0, pass SHALL become 1, and the FSM SHALL stay in ISSUE
- otherwise: the FSM SHALL go to DONE
REQ-012 In DONE, done_o=1 for exactly one cycle, then the FSM SHALL go to IDLE with wr_ptr, rd_ptr and pass cleared.
REQ-013 load_i in ISSUE or DONE SHALL be dropped with no buffer write, and SHALL set overflow_o.
REQ-014 overflow_o SHALL clear only on flush_i or reset.
REQ-015 count_o SHALL equal wr_ptr in FILL and ISSUE, and SHALL be 0 in IDLE and DONE.
REQ-016 flush_i SHALL have priority over all other inputs in every state.
REQ-017 When flush_i=1, the next state SHALL be IDLE, with pointers, pass and overflow_o cleared; buffer contents need not be cleared.
REQ-018 load_i and flush_i in the same cycle: flush SHALL win, and the word SHALL NOT be stored.
REQ-019 instr_valid_o SHALL be 0 in every state except ISSUE.
REQ-020 First-word latency SHALL be: instr_valid_o rises 2 cycles after the clock edge that stores the final word.
REQ-021 A word stored at edge N SHALL be readable for issue from edge N+1.
REQ-022 Pointer widths SHALL hold the value len without overflow; wr_ptr SHALL never exceed len.

Reset
REQ-023 rst_ni=0 SHALL asynchronously force:
- state=IDLE
- wr_ptr=0, rd_ptr=0, pass=0
- latched mode=0
- instr_valid_o=0, busy_o=0, done_o=0, overflow_o=0, count_o=0
- instr_o=0
REQ-024 Reset asserted mid-FILL or mid-ISSUE SHALL abandon the sequence.
REQ-025 After rst_ni deasserts, the next load_i SHALL be treated as word 0.
REQ-026 Buffer memory SHALL need no reset.

Verification
REQ-027 Normal fill, change_i=2'b00, words 0x10..0x17 with ready=1 -> instr_o 0x10..0x17 on 8 consecutive cycles, then done_o pulse, busy_o=0 the next cycle.
REQ-028 Redirect with replay, change_i=2'b11, words 0xA0..0xA3 -> issue sequence 0xA0,A1,A2,A3,A0,A1,A2,A3, then a single done_o.
REQ-029 Backpressure: ready low for 3 cycles on word 2 -> instr_o holds word 2 and valid stays 1; order is unchanged and no word is lost.
REQ-030 Load during ISSUE -> overflow_o=1 and the issued words are unchanged; a following flush_i -> overflow_o=0, state IDLE, count_o=0.
REQ-031 Async reset after 5 of 8 words loaded -> all outputs 0 immediately; a new 8-word load issues only the new words.
REQ-032 Same-cycle load_i and flush_i in IDLE -> count_o stays 0 and busy_o stays 0.
